// File: rtl/detector_borda_pkg.sv
// Edge-mode encoding shared by the edge detector and anything that drives its modo input.
package detector_borda_pkg;

   localparam logic [1:0] MODO_DESLIG  = 2'b00;
   localparam logic [1:0] MODO_SUBIDA  = 2'b01;
   localparam logic [1:0] MODO_DESCIDA = 2'b10;
   localparam logic [1:0] MODO_AMBAS   = 2'b11;

   function automatic logic modo_aceita_subida(input logic [1:0] modo);
      return (modo == MODO_SUBIDA) || (modo == MODO_AMBAS);
   endfunction

   function automatic logic modo_aceita_descida(input logic [1:0] modo);
      return (modo == MODO_DESCIDA) || (modo == MODO_AMBAS);
   endfunction

endpackage

// File: rtl/filtro_canal.sv
// One channel: synchroniser chain, debounce counter, accepted level and raw
// rise/fall strobes valid in the cycle the accepted level is about to change.
module filtro_canal
   import detector_borda_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic entrada,
   output logic estado,
   output logic sobe,
   output logic desce
);

   localparam int CW = $clog2(FILTER_LEN + 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CW-1:0]          cont_q, cont_d;
   logic                   estado_q, estado_d;
   logic                   s;

   always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-2:0], entrada};
      s        = sync_q[SYNC_STAGES-1];
      cont_d   = cont_q;
      estado_d = estado_q;
      // the counter only runs while the synchronised level disagrees with the accepted one
      if (s == estado_q) begin
         cont_d = '0;
      end else if (cont_q == CW'(FILTER_LEN - 1)) begin
         estado_d = s;
         cont_d   = '0;
      end else begin
         cont_d = cont_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q   <= '0;
         cont_q   <= '0;
         estado_q <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         cont_q   <= cont_d;
         estado_q <= estado_d;
      end
   end

   assign estado = estado_q;
   assign sobe   = estado_d & ~estado_q;
   assign desce  = ~estado_d & estado_q;

endmodule

// File: rtl/detector_borda_filtrado.sv
// Multi-channel debounced edge detector: per-channel filters, global edge mode,
// sticky pending/overrun flags with per-channel clear, and a registered irq.
module detector_borda_filtrado
   import detector_borda_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] entrada,
   input  logic [1:0]       modo,
   input  logic [WIDTH-1:0] limpar,
   output logic [WIDTH-1:0] estado,
   output logic [WIDTH-1:0] detector,
   output logic [WIDTH-1:0] pendente,
   output logic [WIDTH-1:0] perdido,
   output logic             irq
);

   logic [WIDTH-1:0] sobe, desce, evento;
   logic [WIDTH-1:0] detector_q, detector_d;
   logic [WIDTH-1:0] pendente_q, pendente_d;
   logic [WIDTH-1:0] perdido_q, perdido_d;
   logic             irq_q, irq_d;

   for (genvar i = 0; i < WIDTH; i++) begin : g_canal
      filtro_canal #(
         .SYNC_STAGES (SYNC_STAGES),
         .FILTER_LEN  (FILTER_LEN)
      ) u_filtro (
         .clk     (clk),
         .rst     (rst),
         .entrada (entrada[i]),
         .estado  (estado[i]),
         .sobe    (sobe[i]),
         .desce   (desce[i])
      );
   end

   always_comb begin
      evento = (sobe  & {WIDTH{modo_aceita_subida(modo)}})
             | (desce & {WIDTH{modo_aceita_descida(modo)}});
      detector_d = evento;
      // a new event beats a simultaneous clear; clearing drops both sticky flags
      pendente_d = evento | (pendente_q & ~limpar);
      perdido_d  = (perdido_q | (evento & pendente_q)) & ~(limpar & ~evento);
      irq_d      = |pendente_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         detector_q <= '0;
         pendente_q <= '0;
         perdido_q  <= '0;
         irq_q      <= 1'b0;
      end else begin
         detector_q <= detector_d;
         pendente_q <= pendente_d;
         perdido_q  <= perdido_d;
         irq_q      <= irq_d;
      end
   end

   assign detector = detector_q;
   assign pendente = pendente_q;
   assign perdido  = perdido_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_detector_borda_filtrado.sv
// Scoreboard bench: stimulus pushes expected detector pulses, a monitor pops on every pulse.
module tb_detector_borda_filtrado;

   typedef struct {
      int         ciclo;
      logic [7:0] mascara;
      logic [7:0] perd;
   } esperado_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] entrada = '0;
   logic [1:0] modo = 2'b01;
   logic [7:0] limpar = '0;
   logic [7:0] estado, detector, pendente, perdido;
   logic       irq;

   logic [0:0] entrada1 = '0;
   logic [1:0] modo1 = 2'b01;
   logic [0:0] limpar1 = '0;
   logic [0:0] estado1, detector1, pendente1, perdido1;
   logic       irq1;

   int        cyc = 0;
   int        n_vec = 0;
   int        n_err = 0;
   esperado_t sb[$];

   detector_borda_filtrado dut (
      .clk(clk), .rst(rst), .entrada(entrada), .modo(modo), .limpar(limpar),
      .estado(estado), .detector(detector), .pendente(pendente),
      .perdido(perdido), .irq(irq)
   );

   detector_borda_filtrado #(.WIDTH(1), .SYNC_STAGES(2), .FILTER_LEN(1)) dut1 (
      .clk(clk), .rst(rst), .entrada(entrada1), .modo(modo1), .limpar(limpar1),
      .estado(estado1), .detector(detector1), .pendente(pendente1),
      .perdido(perdido1), .irq(irq1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nome, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input int atraso, input logic [7:0] m, input logic [7:0] p);
      esperado_t e;
      e.ciclo = cyc + atraso;
      e.mascara = m;
      e.perd = p;
      sb.push_back(e);
   endtask

   // monitor: every pulse on detector must match the oldest expected event
   always @(negedge clk) begin
      if (detector != 8'h00) begin
         if (sb.size() == 0) begin
            chk("unexpected_pulse", {24'h0, detector}, 32'h0);
         end else begin
            esperado_t e;
            e = sb.pop_front();
            chk("pulse_cycle", cyc, e.ciclo);
            chk("pulse_mask", {24'h0, detector}, {24'h0, e.mascara});
            chk("pulse_pendente", {24'h0, pendente & e.mascara}, {24'h0, e.mascara});
            chk("pulse_perdido", {24'h0, perdido & e.mascara}, {24'h0, e.perd});
         end
      end
   end

   initial begin
      // reset state
      tick(3);
      chk("rst_estado", {24'h0, estado}, 32'h0);
      chk("rst_detector", {24'h0, detector}, 32'h0);
      chk("rst_pendente", {24'h0, pendente}, 32'h0);
      chk("rst_perdido", {24'h0, perdido}, 32'h0);
      chk("rst_irq", {31'h0, irq}, 32'h0);
      rst = 1'b0;
      tick(2);

      // 1: rising edge on ch0, latency 5, irq one edge later
      entrada[0] = 1'b1;
      push(6, 8'h01, 8'h00);
      tick(6);
      chk("t1_irq_same_edge", {31'h0, irq}, 32'h0);
      tick(1);
      chk("t1_irq", {31'h0, irq}, 32'h1);
      chk("t1_pendente", {24'h0, pendente}, 32'h01);
      chk("t1_estado", {24'h0, estado}, 32'h01);
      limpar[0] = 1'b1;
      tick(1);
      limpar = '0;
      chk("t1_clear_pend", {24'h0, pendente}, 32'h0);
      tick(1);
      chk("t1_clear_irq", {31'h0, irq}, 32'h0);

      // 2: 3-cycle glitch on ch3 is rejected
      entrada[3] = 1'b1;
      tick(3);
      entrada[3] = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         chk("t2_glitch_estado", {31'h0, estado[3]}, 32'h0);
      end
      chk("t2_pendente", {24'h0, pendente}, 32'h0);

      // 3: mode sweep on ch1
      modo = 2'b01;
      entrada[1] = 1'b1; push(6, 8'h02, 8'h00); tick(8);
      entrada[1] = 1'b0; tick(8);
      limpar[1] = 1'b1; tick(1); limpar = '0;
      modo = 2'b10;
      entrada[1] = 1'b1; tick(8);
      entrada[1] = 1'b0; push(6, 8'h02, 8'h00); tick(8);
      limpar[1] = 1'b1; tick(1); limpar = '0;
      modo = 2'b11;
      entrada[1] = 1'b1; push(6, 8'h02, 8'h00); tick(8);
      entrada[1] = 1'b0; push(6, 8'h02, 8'h02); tick(8);
      limpar[1] = 1'b1; tick(1); limpar = '0;
      modo = 2'b00;
      entrada[1] = 1'b1; tick(7);
      chk("t3_off_estado_hi", {31'h0, estado[1]}, 32'h1);
      entrada[1] = 1'b0; tick(7);
      chk("t3_off_estado_lo", {31'h0, estado[1]}, 32'h0);
      chk("t3_off_pendente", {24'h0, pendente}, 32'h0);

      // 4: overrun and clear on ch2
      modo = 2'b11;
      entrada[2] = 1'b1; push(6, 8'h04, 8'h00); tick(8);
      entrada[2] = 1'b0; push(6, 8'h04, 8'h04); tick(8);
      chk("t4_pend", {31'h0, pendente[2]}, 32'h1);
      chk("t4_perd", {31'h0, perdido[2]}, 32'h1);
      chk("t4_irq", {31'h0, irq}, 32'h1);
      limpar[2] = 1'b1; tick(1); limpar = '0;
      chk("t4_clr_pend", {24'h0, pendente}, 32'h0);
      chk("t4_clr_perd", {24'h0, perdido}, 32'h0);
      entrada[2] = 1'b1; push(6, 8'h04, 8'h00); tick(5);
      limpar[2] = 1'b1; tick(1); limpar = '0;
      chk("t4_setwins_pend", {31'h0, pendente[2]}, 32'h1);
      chk("t4_setwins_perd", {31'h0, perdido[2]}, 32'h0);
      tick(1);
      chk("t4_hold_pend", {31'h0, pendente[2]}, 32'h1);

      // 5: reset mid-filter on ch5
      modo = 2'b01;
      entrada = '0; tick(8);
      limpar = 8'hFF; tick(1); limpar = '0;
      chk("t5_pre_pend", {24'h0, pendente}, 32'h0);
      entrada[5] = 1'b1; tick(4);
      rst = 1'b1; tick(1);
      chk("t5_rst_estado", {24'h0, estado}, 32'h0);
      chk("t5_rst_detector", {24'h0, detector}, 32'h0);
      chk("t5_rst_pendente", {24'h0, pendente}, 32'h0);
      chk("t5_rst_perdido", {24'h0, perdido}, 32'h0);
      chk("t5_rst_irq", {31'h0, irq}, 32'h0);
      tick(1);
      rst = 1'b0;
      push(6, 8'h20, 8'h00);
      tick(7);
      chk("t5_estado", {24'h0, estado}, 32'h20);
      chk("t5_irq", {31'h0, irq}, 32'h1);

      // 6: WIDTH=1, FILTER_LEN=1 instance, single-cycle input accepted after 2 cycles
      entrada1 = 1'b1; tick(1);
      entrada1 = 1'b0;
      for (int i = 2; i <= 6; i++) begin
         tick(1);
         chk("t6_detector", {31'h0, detector1}, (i == 3) ? 32'h1 : 32'h0);
         chk("t6_estado", {31'h0, estado1}, (i == 3) ? 32'h1 : 32'h0);
         chk("t6_pendente", {31'h0, pendente1}, (i >= 3) ? 32'h1 : 32'h0);
      end

      tick(10);
      chk("sb_drained", sb.size(), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/detector_borda_filtrado.md
# detector_borda_filtrado

Multi-channel edge detector with per-channel input synchroniser, debounce filter, selectable edge mode and sticky pending flags with per-channel clear. It turns raw asynchronous inputs such as buttons, switches and external strobes into clean one-cycle event pulses and latched interrupt-style status. It sits between the board I/O pins and the control logic that consumes events.

## Interface

Parameters:
- `WIDTH`, 8: number of independent channels (≥1).
- `SYNC_STAGES`, 2: synchroniser flops per channel (≥2).
- `FILTER_LEN`, 4: consecutive synchronised cycles a new level must hold before it is accepted (≥1). Counter width is `$clog2(FILTER_LEN+1)`.

Ports (one clock, `clk`; reset `rst` is synchronous and active-high):
- `clk` in 1: clock, all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `entrada` in WIDTH: raw, asynchronous channel inputs.
- `modo` in 2: global edge mode. 00 off, 01 rising, 10 falling, 11 both.
- `limpar` in WIDTH: per-channel clear of `pendente`/`perdido`, level-sampled each cycle.
- `estado` out WIDTH: filtered, debounced level per channel.
- `detector` out WIDTH: one-cycle pulse per qualified edge.
- `pendente` out WIDTH: sticky "event occurred" flag per channel.
- `perdido` out WIDTH: sticky overrun flag per channel. Set when an event arrives while `pendente` is already set.
- `irq` out 1: OR-reduction of `pendente`, registered.

## Operation

- Reset (`rst`=1 at a posedge) clears sync chains, filter counters, `estado`, `detector`, `pendente`, `perdido` and `irq` to 0. It has priority over all other activity, including mid-filter counts.
- Synchroniser: `entrada[i]` passes through `SYNC_STAGES` flops. The last stage is `s[i]`.
- Filter, per channel, with counter `c` and accepted level `estado`:
  - If `s == estado`: set `c <= 0`.
  - Else, if `c == FILTER_LEN-1`: set `estado <= s` and `c <= 0`.
  - Else: set `c <= c+1`.
  - A glitch shorter than `FILTER_LEN` synchronised cycles never changes `estado`.
  - With `FILTER_LEN`=1, `estado` follows `s` one cycle later.
- Edge qualification happens in the same cycle `estado` updates:
  - A rising edge is `estado` going 0→1. A falling edge is `estado` going 1→0.
  - `detector[i] <= edge qualified by modo`.
  - `modo`=00 suppresses all pulses; the filter keeps tracking.
- Pending flags, per channel, per cycle:
  - If the event (new `detector`) is set and `pendente` is already 1: set `perdido`.
  - If the event is set: `pendente <= 1`. Set wins over a simultaneous `limpar`.
  - Else, if `limpar`: `pendente <= 0` and `perdido <= 0`.
- `irq` is registered `|pendente`, one cycle behind `pendente`.
- A `modo` change takes effect on the first posedge where it is sampled. It does not retroactively create or cancel pulses.
- Because reset state is 0, an input held high through reset produces a rising-edge event after the normal latency.

## Timing

- Latency: a clean level change on `entrada` first captured at posedge k appears on `estado`/`detector` at posedge k+SYNC_STAGES+FILTER_LEN-1. Defaults: k+5.
- `pendente` rises on the same edge as `detector`. `irq` rises one edge later.
- `detector` is high for exactly one cycle per accepted transition.
- Minimum spacing between two events on one channel is `FILTER_LEN` cycles.
- `limpar` acts on the edge it is sampled. `pendente` reads 0 the next cycle unless a new event coincides.
- Channels are fully independent. Simultaneous events on all channels are all captured.

## Structure

- Package `detector_borda_pkg` holds the `modo` encoding constants `MODO_DESLIG`=2'b00, `MODO_SUBIDA`=2'b01, `MODO_DESCIDA`=2'b10 and `MODO_AMBAS`=2'b11.
- Sub-module `filtro_canal` covers one channel: sync chain, debounce counter, `estado` and raw rise/fall strobes. The top generates `WIDTH` copies and adds mode qualification, `pendente`/`perdido` and `irq`.

## Test plan

1. Reset release with `entrada`=0, `modo`=01, defaults. Drive `entrada[0]` 0→1 and hold → `detector[0]` pulses once at +5 cycles; `pendente[0]`=1; `irq`=1 one cycle later; other channels stay 0.
2. Glitch: `entrada[3]` high for 3 cycles, then low (`FILTER_LEN`=4) → `estado[3]`, `detector[3]` and `pendente[3]` stay 0 throughout.
3. Mode sweep on ch 1 with a toggle 0→1→0: `modo`=01 gives one pulse on the rise; 10 gives one pulse on the fall; 11 gives two pulses; 00 gives none, while `estado[1]` still tracks.
4. Overrun and clear on ch 2: two events without `limpar` → `pendente`=1, `perdido`=1. Pulse `limpar[2]` → both 0 next cycle. Assert `limpar[2]` on the same edge as a new event → `pendente[2]`=1, `perdido[2]`=0.
5. Reset mid-filter: start a transition on ch 5, assert `rst` at count 2 → all outputs 0. Release with input still high → event after the full 5-cycle latency from release.
6. `WIDTH`=1, `FILTER_LEN`=1, `SYNC_STAGES`=2: a single-cycle input change is accepted with 2-cycle latency and pulses once.
